irq_aggregator: RTL and testbench

- Collects up to 16 interrupt request lines into one registered `irq_out` for the processor.
- Sources: the interval timer's `irq`, the audio/convolution core interrupts, and any other peripheral interrupts.
- Per source: two-flop synchronisation, edge or level capture, masking, plus a fixed-priority vector.
- Optional hold-off counter prevents interrupt storms.
- Sits directly downstream of the interval timer and the other peripheral slaves.
- Programmed over the same 16-bit Avalon-MM slave style: 3-bit address, registered readdata.

---
 rtl/irq_aggregator_if.sv | 12 +
 rtl/irq_aggregator.sv | 100 ++++++++++
 tb/tb_irq_aggregator.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_aggregator_if.sv
// Register-access port of the interrupt aggregator: 3-bit address, 16-bit data,
// single-cycle writes qualified by chipselect, registered readdata.
interface irq_aggregator_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_aggregator.sv
// Synchronises, captures (edge/level), masks and prioritises up to 16 interrupt
// sources into one registered irq_out, with an optional post-deassert hold-off.
module irq_aggregator #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  irq_aggregator_if.slave  bus,
  input  logic [N_SRC-1:0] irq_in,
  output logic             irq_out
);

  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] pending, mask, edge_mode;
  logic [N_SRC-1:0] active, rise, clr, to_edge, pending_nxt;
  logic [15:0]      holdoff, holdoff_cnt, vector, rd_nxt;
  logic             irq_prev, wr, fell, irq_nxt;

  assign wr     = bus.chipselect && !bus.write_n;
  assign active = pending & mask;
  assign rise   = s2 & ~s3;
  assign fell   = irq_prev && !irq_out;

  // Pending clears come from a PENDING W1C or an in-range ACK index.
  always_comb begin
    clr = '0;
    if (wr && bus.address == 3'd0)
      clr = bus.writedata[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++)
      if (wr && bus.address == 3'd5 && bus.writedata[3:0] == 4'(i))
        clr[i] = 1'b1;
  end

  // Sources switching into edge mode start empty; the set term wins over clr.
  assign to_edge     = (wr && bus.address == 3'd2) ? (bus.writedata[N_SRC-1:0] & ~edge_mode) : '0;
  assign pending_nxt = (edge_mode & (rise | (pending & ~clr)))
                     | (~edge_mode & ~to_edge & s2);

  always_comb begin
    vector = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[i])
        vector = {1'b1, 11'd0, 4'(i)};
  end

  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      3'd0:    rd_nxt = 16'(pending);
      3'd1:    rd_nxt = 16'(mask);
      3'd2:    rd_nxt = 16'(edge_mode);
      3'd3:    rd_nxt = 16'(active);
      3'd4:    rd_nxt = vector;
      3'd6:    rd_nxt = holdoff;
      3'd7:    rd_nxt = 16'(s2);
      default: rd_nxt = '0;
    endcase
  end

  // Hold-off only gates a fresh assertion; the edge right after a fall is
  // always blocked so re-assertion is no earlier than two edges plus the reload.
  assign irq_nxt = (|active) && (irq_out || (holdoff_cnt == 16'd0 && !fell));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      pending      <= '0;
      mask         <= '0;
      edge_mode    <= '0;
      holdoff      <= '0;
      holdoff_cnt  <= '0;
      irq_prev     <= 1'b0;
      irq_out      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s3      <= s2;
      pending <= pending_nxt;
      if (wr) begin
        case (bus.address)
          3'd1:    mask      <= bus.writedata[N_SRC-1:0];
          3'd2:    edge_mode <= bus.writedata[N_SRC-1:0];
          3'd6:    holdoff   <= bus.writedata;
          default: ;
        endcase
      end
      if (fell)
        holdoff_cnt <= holdoff;
      else if (holdoff_cnt != 16'd0)
        holdoff_cnt <= holdoff_cnt - 16'd1;
      irq_prev     <= irq_out;
      irq_out      <= irq_nxt;
      bus.readdata <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed and randomized bench for irq_aggregator against a timestamp-based
// reference model of the register map, capture rules and hold-off window.
module tb_irq_aggregator;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         irq_out;

  irq_aggregator_if bus();

  irq_aggregator #(.N_SRC(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: input history queue, register images, and the hold-off
  // expressed as the earliest cycle number at which irq_out may rise again.
  logic [N-1:0] samp [$];
  logic [N-1:0] m_pend, m_mask, m_edge;
  logic [15:0]  m_hold, m_rd;
  logic         m_irq, m_fell;
  int           cyc, ready;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp = {N'(0), N'(0), N'(0)};
    m_pend = '0; m_mask = '0; m_edge = '0;
    m_hold = '0; m_rd = '0; m_irq = 1'b0; m_fell = 1'b0;
    cyc = 0; ready = 0;
  endtask

  task automatic model_step();
    logic         wr;
    logic [N-1:0] s2, s3, act, clr, to_edge, np;
    logic [15:0]  vec;
    wr  = bus.chipselect && !bus.write_n;
    s2  = samp[1];
    s3  = samp[2];
    act = m_pend & m_mask;
    cyc++;

    vec = 16'h0000;
    for (int i = 0; i < N; i++)
      if (act[i]) begin vec = 16'h8000 | 16'(i); break; end
    case (bus.address)
      3'd0: m_rd = 16'(m_pend);
      3'd1: m_rd = 16'(m_mask);
      3'd2: m_rd = 16'(m_edge);
      3'd3: m_rd = 16'(act);
      3'd4: m_rd = vec;
      3'd6: m_rd = m_hold;
      3'd7: m_rd = 16'(s2);
      default: m_rd = 16'h0000;
    endcase

    clr = '0;
    if (wr && bus.address == 3'd0) clr = bus.writedata[N-1:0];
    if (wr && bus.address == 3'd5 && int'(bus.writedata[3:0]) < N) clr[bus.writedata[2:0]] = 1'b1;
    to_edge = (wr && bus.address == 3'd2) ? (bus.writedata[N-1:0] & ~m_edge) : '0;
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) np[i] = (s2[i] && !s3[i]) || (m_pend[i] && !clr[i]);
      else           np[i] = to_edge[i] ? 1'b0 : s2[i];
    end

    if (m_fell) ready = cyc + 1 + int'(m_hold);
    m_fell = 1'b0;
    if (m_irq && !(|act)) m_fell = 1'b1;
    m_irq = (|act) && (m_irq || cyc >= ready);

    m_pend = np;
    if (wr && bus.address == 3'd1) m_mask = bus.writedata[N-1:0];
    if (wr && bus.address == 3'd2) m_edge = bus.writedata[N-1:0];
    if (wr && bus.address == 3'd6) m_hold = bus.writedata;
    samp.push_front(irq_in);
    void'(samp.pop_back());
  endtask

  // One clock: model advances on the edge, outputs compared 1 ns later,
  // returns at the falling edge where the next inputs are driven.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    check("irq_model", 16'(irq_out), 16'(m_irq));
    check("rd_model", bus.readdata, m_rd);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    bus.address = a; bus.chipselect = 1'b1;
    tick();
    v = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int lowcnt;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    model_reset();
    @(negedge clk);
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset defaults
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      check("reset_reg", v, 16'h0000);
    end
    check("reset_irq", 16'(irq_out), 16'h0000);

    // Level path on source 0
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("level_rise_lat", 16'(irq_out), 16'(t == 4));
    end
    rd(3'd4, v);  check("level_vector", v, 16'h8000);
    wr(3'd0, 16'h0001);
    rd(3'd0, v);  check("level_w1c_ignored", v, 16'h0001);
    irq_in[0] = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("level_fall_lat", 16'(irq_out), 16'(t < 4));
    end
    wr(3'd1, 16'h0000);

    // Edge capture and ACK on sources 2 and 3
    wr(3'd2, 16'h000C);
    wr(3'd1, 16'h000C);
    irq_in[3:2] = 2'b11;
    repeat (2) tick();
    irq_in[3:2] = 2'b00;
    repeat (3) tick();
    rd(3'd0, v);  check("edge_pending", v, 16'h000C);
    rd(3'd4, v);  check("edge_vector2", v, 16'h8002);
    wr(3'd5, 16'h0002);
    rd(3'd4, v);  check("edge_vector3", v, 16'h8003);
    wr(3'd5, 16'h0003);
    check("ack_same_edge", 16'(irq_out), 16'h0001);
    tick();
    check("ack_deassert", 16'(irq_out), 16'h0000);

    // Same-edge rise and W1C on source 5
    wr(3'd2, 16'h002C);
    irq_in[5] = 1'b1;
    repeat (2) tick();
    wr(3'd0, 16'h0020);
    irq_in[5] = 1'b0;
    rd(3'd0, v);  check("set_beats_clear", v, 16'h0020);
    wr(3'd5, 16'h0005);

    // Hold-off of 10 after an ACKed edge event, with a new event right behind
    wr(3'd6, 16'd10);
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    repeat (2) tick();
    irq_in[2] = 1'b0;
    for (int i = 0; i < 20 && !irq_out; i++) tick();
    check("holdoff_armed", 16'(irq_out), 16'h0001);
    wr(3'd5, 16'h0002);
    irq_in[2] = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) irq_in[2] = 1'b0;
      tick();
      if (irq_out) break;
      lowcnt++;
    end
    check("holdoff_min11", 16'(lowcnt >= 11), 16'h0001);
    check("holdoff_exact", 16'(lowcnt), 16'd12);
    wr(3'd5, 16'h0002);
    wr(3'd6, 16'd0);

    // Unimplemented mask bits and out-of-range ACK index
    wr(3'd1, 16'hFFFF);
    rd(3'd1, v);  check("mask_width", v, 16'h00FF);
    wr(3'd2, 16'h00FF);
    irq_in = '1;
    repeat (2) tick();
    irq_in = '0;
    repeat (3) tick();
    rd(3'd0, v);  check("all_pending", v, 16'h00FF);
    wr(3'd5, 16'd12);
    rd(3'd0, v);  check("ack12_ignored", v, 16'h00FF);
    rd(3'd5, v);  check("ack_reads0", v, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) irq_in = N'($urandom);
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n    = 1'($urandom_range(0, 1));
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = (bus.address == 3'd6) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      tick();
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;

    // Asynchronous reset while irq_out is high
    irq_in = '0;
    irq_in[0] = 1'b1;
    wr(3'd6, 16'd0);
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0001);
    repeat (25) tick();
    check("pre_reset_irq", 16'(irq_out), 16'h0001);
    #2 reset_n = 1'b0;
    #1 check("async_reset_irq", 16'(irq_out), 16'h0000);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    rd(3'd1, v);  check("post_reset_mask", v, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
